mm_sequencer: RTL and testbench
===============================

MM_SEQUENCER -- requirements
Module: mm_sequencer

Interface
REQ-001 SHALL have parameter D_W_ACC, default 16, accumulator/result data width.
REQ-002 SHALL have parameter N1, default 4, array rows.
REQ-003 SHALL have parameter N2, default 4, array columns.
REQ-004 SHALL have parameter M, default 8, matrix dimension; M divisible by N1 and N2.
REQ-005 SHALL have parameter DRAIN_TO, default 64, drain timeout in cycles.
REQ-006 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port start, input, 1, one-cycle job request.
REQ-009 SHALL have port abort, input, 1, one-cycle job cancel.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-012 SHALL have port err, output, 1, sticky error flag; cleared on accepted start.
REQ-013 SHALL have port array_rst, output, 1, active-high synchronous reset to the systolic array.
REQ-014 SHALL have port enable_row_count_A, output, 1, streaming enable to the array.
REQ-015 SHALL have port valid_D, input, N1, per-row result valid from the array.
REQ-016 SHALL have port D, input, N1 x D_W_ACC, per-row result data.
REQ-017 SHALL have port wr_en, output, N1, per-row result-memory write strobe.
REQ-018 SHALL have port wr_addr, output, N1 x clog2(M*M/N1), per-row write address.
REQ-019 SHALL have port wr_data, output, N1 x D_W_ACC, per-row write data.

Function
REQ-020 SHALL implement states IDLE, CLR, RUN, DRAIN, DONE.
REQ-021 IDLE: start=1 and abort=0 SHALL go to CLR, clear err, and clear all beat counters.
REQ-022 CLR SHALL last exactly 1 cycle, with array_rst=1, then go to RUN.
REQ-023 RUN SHALL hold enable_row_count_A=1 for exactly T_RUN = M*(M/N1)*(M/N2) cycles (32 at defaults), then go to DRAIN.
REQ-024 Per row r, a beat counter SHALL count accepted valid_D[r] beats; quota Q = M*M/N1 (16 at defaults).
REQ-025 valid_D[r] SHALL be accepted only in RUN or DRAIN while cnt[r] < Q.
REQ-026 An accepted beat SHALL drive, one cycle later, wr_en[r]=1, wr_data[r]=D[r] (registered), and wr_addr[r]=cnt[r] before increment.
REQ-027 valid_D[r] while cnt[r]=Q SHALL be dropped (no wr_en) and SHALL set err.
REQ-028 DRAIN SHALL go to DONE in the cycle after all cnt[r]=Q.
REQ-029 DRAIN SHALL go to IDLE with err=1 and no done after DRAIN_TO cycles without completion.
REQ-030 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-031 abort in CLR, RUN or DRAIN SHALL go to IDLE next cycle, drive array_rst=1 for that 1 cycle, drop enable_row_count_A, and produce no done.
REQ-032 start and abort together in IDLE: abort SHALL win and start SHALL be ignored.
REQ-033 start while busy=1 SHALL be ignored.
REQ-034 valid_D SHALL be ignored in IDLE, CLR and DONE.
REQ-035 The RUN counter and drain timer SHALL be exactly wide enough for T_RUN and DRAIN_TO, with no wrap inside a job.

Reset
REQ-036 rst=0 SHALL asynchronously force IDLE, with busy, done, err, enable_row_count_A, wr_en and array_rst all 0, and all counters, wr_addr and wr_data at 0.
REQ-037 A reset asserted mid-job SHALL discard the job, with no done and no further wr_en.

Structure
REQ-038 The state enum and the derived constants T_RUN and Q SHALL live in shared package mm_pkg.
REQ-039 Per-row beat counting and write registering SHALL be one sub-module, mm_row_writer, instantiated N1 times.

Verification
REQ-040 Defaults, start pulse, model array producing 16 beats/row during RUN/DRAIN -> array_rst high 1 cycle, enable high exactly 32 cycles, wr_addr 0..15 per row, done exactly once, err=0.
REQ-041 abort in RUN cycle 10 -> IDLE next cycle, array_rst 1 cycle, enable low, no done, busy=0.
REQ-042 Row 2 gives only 15 beats -> DRAIN times out after 64 cycles, err=1, no done.
REQ-043 17th beat on row 0 -> no wr_en for it, err=1; job still completes with done.
REQ-044 start+abort same cycle in IDLE -> stays IDLE; start during RUN -> ignored, with enable count still 32.
REQ-045 rst low during DRAIN -> all outputs 0 immediately; next start runs a clean job from wr_addr 0.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer: FSM states and the
// job-length constants derived from the array geometry.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Streaming cycles needed to push every A/B tile through the array.
    function automatic int t_run_f(input int m, input int n1, input int n2);
        return m * (m / n1) * (m / n2);
    endfunction

    // Result beats each array row must deliver for one job.
    function automatic int quota_f(input int m, input int n1);
        return m * m / n1;
    endfunction

    function automatic int width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int T_RUN = t_run_f(8, 4, 4);
    localparam int Q     = quota_f(8, 4);

endpackage

// File: rtl/mm_row_writer.sv
// One array row: counts accepted result beats up to the quota and registers
// each accepted beat into a result-memory write.
module mm_row_writer #(
    parameter int D_W_ACC = 16,
    parameter int QUOTA   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       active,
    input  logic                       valid,
    input  logic [D_W_ACC-1:0]         d,
    output logic                       wr_en,
    output logic [$clog2(QUOTA)-1:0]   wr_addr,
    output logic [D_W_ACC-1:0]         wr_data,
    output logic                       full,
    output logic                       overflow
);

    localparam int AW = $clog2(QUOTA);
    localparam int CW = $clog2(QUOTA + 1);

    logic [CW-1:0] cnt;
    logic          accept;

    assign full     = (cnt == CW'(QUOTA));
    assign accept   = active && valid && !full;
    assign overflow = active && valid && full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (clr) begin
                cnt <= '0;
            end else if (accept) begin
                // Address is the beat index before this beat is counted.
                cnt     <= cnt + CW'(1);
                wr_addr <= cnt[AW-1:0];
                wr_data <= d;
            end
        end
    end

endmodule

// File: rtl/mm_sequencer.sv
// Job sequencer for an N1 x N2 systolic array: clears the array, streams for a
// fixed number of cycles, then drains per-row results into result memory.
module mm_sequencer
    import mm_pkg::*;
#(
    parameter int D_W_ACC  = 16,
    parameter int N1       = 4,
    parameter int N2       = 4,
    parameter int M        = 8,
    parameter int DRAIN_TO = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             array_rst,
    output logic                             enable_row_count_A,
    input  logic [N1-1:0]                    valid_D,
    input  logic [N1*D_W_ACC-1:0]            D,
    output logic [N1-1:0]                    wr_en,
    output logic [N1*$clog2(M*M/N1)-1:0]     wr_addr,
    output logic [N1*D_W_ACC-1:0]            wr_data,
    output logic [2:0]                       dbg_state
);

    localparam int RUN_LEN = t_run_f(M, N1, N2);
    localparam int QUOTA   = quota_f(M, N1);
    localparam int AW      = $clog2(QUOTA);
    localparam int RW      = width_f(RUN_LEN);
    localparam int DW      = width_f(DRAIN_TO);
    localparam logic [RW-1:0] RUN_LAST   = RW'(RUN_LEN - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TO - 1);

    state_t        state, state_nxt;
    logic [RW-1:0] run_cnt;
    logic [DW-1:0] drain_cnt;
    logic          abort_rst;
    logic          accept_start, aborting, timeout, active, all_full;
    logic [N1-1:0] full, ovf;

    assign active   = (state == RUN) || (state == DRAIN);
    assign all_full = &full;

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        aborting     = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                // abort outranks a simultaneous start
                if (start && !abort) begin
                    state_nxt    = CLR;
                    accept_start = 1'b1;
                end
            end
            CLR: begin
                if (abort) begin
                    state_nxt = IDLE;
                    aborting  = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    aborting  = 1'b1;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    aborting  = 1'b1;
                end else if (all_full) begin
                    state_nxt = DONE;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = IDLE;
                    timeout   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            run_cnt   <= '0;
            drain_cnt <= '0;
            abort_rst <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            run_cnt   <= (state == RUN && state_nxt == RUN) ? run_cnt + RW'(1) : '0;
            drain_cnt <= (state == DRAIN && state_nxt == DRAIN) ? drain_cnt + DW'(1) : '0;
            abort_rst <= aborting;
            if (accept_start) begin
                err <= 1'b0;
            end else if (timeout || (|ovf)) begin
                err <= 1'b1;
            end
        end
    end

    assign busy               = (state != IDLE);
    assign done               = (state == DONE);
    assign enable_row_count_A = (state == RUN);
    assign array_rst          = (state == CLR) || abort_rst;
    assign dbg_state          = state;

    for (genvar r = 0; r < N1; r++) begin : g_row
        mm_row_writer #(
            .D_W_ACC (D_W_ACC),
            .QUOTA   (QUOTA)
        ) u_row (
            .clk      (clk),
            .rst      (rst),
            .clr      (accept_start),
            .active   (active),
            .valid    (valid_D[r]),
            .d        (D[r*D_W_ACC +: D_W_ACC]),
            .wr_en    (wr_en[r]),
            .wr_addr  (wr_addr[r*AW +: AW]),
            .wr_data  (wr_data[r*D_W_ACC +: D_W_ACC]),
            .full     (full[r]),
            .overflow (ovf[r])
        );
    end

endmodule

// File: tb/tb_mm_sequencer.sv
// Self-checking bench for mm_sequencer: vector table, directed job scenarios
// and randomized jobs against a cycle-level job model with a write scoreboard.
module tb_mm_sequencer;
    import mm_pkg::*;

    localparam int DW = 16, N1 = 4, N2 = 4, M = 8, DRAIN_TO = 64;
    localparam int T_RUN = 32, QB = 16, AW = 4, W = 2 + AW + DW;
    localparam int PH_IDLE = 0, PH_JOB = 1, PH_DONE = 2;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [N1-1:0] valid_D;
    logic [N1*DW-1:0] D;
    logic busy, done, err, array_rst, enable_row_count_A;
    logic [N1-1:0] wr_en;
    logic [N1*AW-1:0] wr_addr;
    logic [N1*DW-1:0] wr_data;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    mm_sequencer #(.D_W_ACC(DW), .N1(N1), .N2(N2), .M(M), .DRAIN_TO(DRAIN_TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .err(err), .array_rst(array_rst), .enable_row_count_A(enable_row_count_A),
        .valid_D(valid_D), .D(D), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_state(dbg_state)
    );

    int checks = 0, errors = 0;

    // Job model: phase, cycle index within the job (0 = clear cycle), beats per row.
    int m_ph, m_t, m_cnt[N1];
    bit m_err, m_abort_rst, m_wr_en[N1];
    logic [AW-1:0] m_addr[N1];
    logic [DW-1:0] m_data[N1];
    logic [W-1:0] exp_q[$];

    int beats_left[N1];
    int n_en, n_done, n_arst, n_drain, n_wr[N1];

    typedef struct {
        bit start, abort, busy, arst, en;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_t = 0; m_err = 0; m_abort_rst = 0;
        for (int r = 0; r < N1; r++) begin
            m_cnt[r] = 0; m_wr_en[r] = 0; m_addr[r] = '0; m_data[r] = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        bit all_q, strm;
        all_q = 1;
        for (int r = 0; r < N1; r++) if (m_cnt[r] != QB) all_q = 0;
        strm = (m_ph == PH_JOB) && (m_t >= 1);
        m_abort_rst = 0;
        for (int r = 0; r < N1; r++) begin
            m_wr_en[r] = 0;
            if (strm && valid_D[r]) begin
                if (m_cnt[r] < QB) begin
                    m_wr_en[r] = 1;
                    m_addr[r] = AW'(m_cnt[r]);
                    m_data[r] = D[r*DW +: DW];
                    exp_q.push_back({2'(r), m_addr[r], m_data[r]});
                    m_cnt[r]++;
                end else begin
                    m_err = 1;
                end
            end
        end
        case (m_ph)
            PH_IDLE: if (start && !abort) begin
                m_ph = PH_JOB; m_t = 0; m_err = 0;
                for (int r = 0; r < N1; r++) m_cnt[r] = 0;
            end
            PH_JOB: begin
                if (abort) begin
                    m_ph = PH_IDLE; m_abort_rst = 1;
                end else if (m_t <= T_RUN) begin
                    m_t++;
                end else if (all_q) begin
                    m_ph = PH_DONE;
                end else if (m_t - T_RUN == DRAIN_TO) begin
                    m_ph = PH_IDLE; m_err = 1;
                end else begin
                    m_t++;
                end
            end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    function automatic logic [2:0] exp_state();
        if (m_ph == PH_IDLE) return IDLE;
        if (m_ph == PH_DONE) return DONE;
        if (m_t == 0) return CLR;
        if (m_t <= T_RUN) return RUN;
        return DRAIN;
    endfunction

    task automatic check_outputs();
        logic [W-1:0] e;
        chk("busy", busy, m_ph != PH_IDLE);
        chk("done", done, m_ph == PH_DONE);
        chk("err", err, m_err);
        chk("enable", enable_row_count_A, m_ph == PH_JOB && m_t >= 1 && m_t <= T_RUN);
        chk("array_rst", array_rst, (m_ph == PH_JOB && m_t == 0) || m_abort_rst);
        chk("state", dbg_state, exp_state());
        for (int r = 0; r < N1; r++) begin
            chk("wr_en", wr_en[r], m_wr_en[r]);
            chk("wr_addr", wr_addr[r*AW +: AW], m_addr[r]);
            chk("wr_data", wr_data[r*DW +: DW], m_data[r]);
            if (m_wr_en[r]) begin
                if (exp_q.size() == 0) chk("sb_underrun", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_write", {2'(r), wr_addr[r*AW +: AW], wr_data[r*DW +: DW]}, e);
                end
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk); #1;
        check_outputs();
        n_en += enable_row_count_A; n_done += done; n_arst += array_rst;
        n_drain += (busy && !enable_row_count_A && !array_rst && !done);
        for (int r = 0; r < N1; r++) n_wr[r] += wr_en[r];
    endtask

    task automatic mid_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        check_outputs();
        @(posedge clk); #1;
        check_outputs();
        rst = 1'b1;
    endtask

    task automatic drive_beats(input bit spam, input bit dense, input bit junk);
        bit strm;
        strm = (m_ph == PH_JOB) && (m_t >= 1);
        D = {$urandom(), $urandom()};
        for (int r = 0; r < N1; r++) begin
            if (strm && beats_left[r] > 0 && (dense || $urandom_range(0, 1) == 1)) begin
                valid_D[r] = 1'b1;
                beats_left[r]--;
            end else begin
                valid_D[r] = !strm && junk && ($urandom_range(0, 3) == 0);
            end
        end
        start = spam && ($urandom_range(0, 3) == 0);
    endtask

    task automatic run_job(input int abort_at, input bit spam, input bit dense,
                           input bit junk, input int rst_drain);
        bit ended;
        n_en = 0; n_done = 0; n_arst = 0; n_drain = 0;
        for (int r = 0; r < N1; r++) n_wr[r] = 0;
        ended = 0;
        valid_D = '0; start = 1'b1; abort = 1'b0;
        step();
        start = 1'b0;
        for (int c = 0; c < 400 && !ended; c++) begin
            drive_beats(spam, dense, junk);
            abort = (abort_at >= 0) && (m_ph == PH_JOB) && (m_t == abort_at);
            step();
            abort = 1'b0;
            if (rst_drain > 0 && m_ph == PH_JOB && m_t == T_RUN + rst_drain) begin
                mid_reset();
                ended = 1;
            end else if (m_ph == PH_IDLE) begin
                ended = 1;
            end
        end
        start = 1'b0; valid_D = '0;
        chk("job_bound", ended, 1);
    endtask

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 1, 0, 1};
        tbl[4]  = '{1, 0, 1, 0, 1};
        tbl[5]  = '{0, 1, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 1, 0};
        tbl[9]  = '{0, 1, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0};

        // Clock/reset
        rst = 1'b0; start = 1'b0; abort = 1'b0; valid_D = '0; D = '0;
        model_reset();
        #1 check_outputs();
        #11 rst = 1'b1;
        @(posedge clk); #1;
        check_outputs();

        for (int i = 0; i < 11; i++) begin
            start = tbl[i].start; abort = tbl[i].abort; valid_D = '0;
            step();
            chk("tbl_busy", busy, tbl[i].busy);
            chk("tbl_array_rst", array_rst, tbl[i].arst);
            chk("tbl_enable", enable_row_count_A, tbl[i].en);
        end
        start = 1'b0; abort = 1'b0;

        // Normal job, 16 beats per row
        for (int r = 0; r < N1; r++) beats_left[r] = QB;
        run_job(-1, 0, 0, 1, 0);
        chk("normal_enable_cycles", n_en, 32);
        chk("normal_done_count", n_done, 1);
        chk("normal_array_rst_cycles", n_arst, 1);
        chk("normal_err", err, 0);
        chk("normal_row3_writes", n_wr[3], 16);

        // Abort in RUN cycle 10
        for (int r = 0; r < N1; r++) beats_left[r] = QB;
        run_job(10, 0, 0, 0, 0);
        chk("abort_enable_cycles", n_en, 10);
        chk("abort_array_rst_cycles", n_arst, 2);
        chk("abort_done_count", n_done, 0);
        chk("abort_busy", busy, 0);

        // Row 2 short by one beat
        for (int r = 0; r < N1; r++) beats_left[r] = QB;
        beats_left[2] = QB - 1;
        run_job(-1, 0, 0, 0, 0);
        chk("timeout_drain_cycles", n_drain, 64);
        chk("timeout_done_count", n_done, 0);
        chk("timeout_err", err, 1);

        // 17th beat on row 0
        for (int r = 0; r < N1; r++) beats_left[r] = QB;
        beats_left[0] = QB + 1;
        run_job(-1, 0, 1, 0, 0);
        chk("extra_row0_writes", n_wr[0], 16);
        chk("extra_err", err, 1);
        chk("extra_done_count", n_done, 1);

        // start pulses while busy
        for (int r = 0; r < N1; r++) beats_left[r] = QB;
        run_job(-1, 1, 0, 0, 0);
        chk("spam_enable_cycles", n_en, 32);
        chk("spam_done_count", n_done, 1);

        // Reset during DRAIN, then a clean job
        for (int r = 0; r < N1; r++) beats_left[r] = QB;
        beats_left[1] = QB - 2;
        run_job(-1, 0, 0, 0, 5);
        chk("rst_drain_done_count", n_done, 0);
        for (int r = 0; r < N1; r++) beats_left[r] = QB;
        run_job(-1, 0, 0, 0, 0);
        chk("post_rst_done_count", n_done, 1);
        chk("post_rst_err", err, 0);
        chk("post_rst_row0_writes", n_wr[0], 16);

        // Randomized jobs
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < N1; r++) beats_left[r] = $urandom_range(QB - 2, QB + 1);
            run_job(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 45)) : -1,
                    $urandom_range(0, 1) == 1, 0, 1, 0);
            repeat ($urandom_range(0, 3)) step();
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
